// File: rtl/lcd_pkg.sv
// Shared constants, FSM state encoding and window-command word builder for the LCD glyph path.
// Pure definitions; no timing or flow-control behaviour of its own.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
    localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
    localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

    localparam logic [6:0] ASCII_FIRST = 7'h20;
    localparam logic [6:0] ASCII_LAST  = 7'h7E;

    typedef enum logic [3:0] {
        IDLE, CHECK, CMD, FETCH, LATCH, PIX_HI, PIX_LO, WAIT, DONE
    } state_t;

    // Word idx of the 11-word window preamble: CASET x0 x1, RASET y0 y1, RAMWR.
    function automatic logic [8:0] cmd_word(input logic [3:0] idx,
                                            input logic [15:0] x0, input logic [15:0] x1,
                                            input logic [15:0] y0, input logic [15:0] y1);
        logic [8:0] w;
        case (idx)
            4'd0:    w = {1'b0, LCD_CMD_CASET};
            4'd1:    w = {1'b1, x0[15:8]};
            4'd2:    w = {1'b1, x0[7:0]};
            4'd3:    w = {1'b1, x1[15:8]};
            4'd4:    w = {1'b1, x1[7:0]};
            4'd5:    w = {1'b0, LCD_CMD_RASET};
            4'd6:    w = {1'b1, y0[15:8]};
            4'd7:    w = {1'b1, y0[7:0]};
            4'd8:    w = {1'b1, y1[15:8]};
            4'd9:    w = {1'b1, y1[7:0]};
            default: w = {1'b0, LCD_CMD_RAMWR};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lcd_show_char_if.sv
// Word channel from an LCD producer to the SPI writer: 9-bit {dc, byte} word, write strobe, completion pulse.
// One word outstanding at a time; the producer holds the word until wr_done.
interface lcd_show_char_if;
    logic [8:0] show_char_data;
    logic       en_write_show_char;
    logic       wr_done;

    modport master (output show_char_data, output en_write_show_char, input wr_done);
    modport slave  (input show_char_data, input en_write_show_char, output wr_done);
endinterface

// File: rtl/lcd_word_issuer.sv
// Registers one word and pulses the write strobe the cycle after issue_vld_i; holds the word until wr_done.
// ack_o flags wr_done only while a word is outstanding, so stray completions are dropped.
module lcd_word_issuer (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_vld_i,
    input  logic [8:0] issue_dat_i,
    input  logic       wr_done_i,
    output logic [8:0] wr_dat_o,
    output logic       wr_en_o,
    output logic       ack_o
);
    logic [8:0] dat_q;
    logic       en_q;
    logic       pend_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q  <= '0;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            en_q <= issue_vld_i;
            if (issue_vld_i) begin
                dat_q  <= issue_dat_i;
                pend_q <= 1'b1;
            end else if (wr_done_i) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign wr_dat_o = dat_q;
    assign wr_en_o  = en_q;
    assign ack_o    = pend_q & wr_done_i;
endmodule

// File: rtl/lcd_show_char.sv
// Draws one 8x16 or 16x32 ASCII glyph: window commands, then RGB565 pixels from the font ROM.
// Each word waits for wr_done before the next is issued; start pulses while busy are ignored.
module lcd_show_char
    import lcd_pkg::*;
#(
    parameter int          LCD_W    = 240,
    parameter int          LCD_H    = 240,
    parameter logic [15:0] FG_COLOR = 16'hFFFF,
    parameter logic [15:0] BG_COLOR = 16'h0000,
    parameter int          FONT_AW  = 12
) (
    input  logic               sys_clk_50MHz,
    input  logic               sys_rst,
    input  logic               show_char_flag,
    input  logic [6:0]         ascii_num,
    input  logic               en_size,
    input  logic [8:0]         start_x,
    input  logic [8:0]         start_y,
    output logic [FONT_AW-1:0] font_addr,
    output logic               font_size,
    input  logic [15:0]        font_q,
    lcd_show_char_if.master    wr,
    output logic               show_char_done,
    output logic               busy
);
    state_t             state_q, state_d, ret_q, ret_d;
    logic [6:0]         code_q, code_d;
    logic               size_q, size_d;
    logic [8:0]         sx_q, sx_d, sy_q, sy_d;
    logic [FONT_AW-1:0] base_q, base_d;
    logic [4:0]         row_q, row_d;
    logic [3:0]         col_q, col_d;
    logic [3:0]         idx_q, idx_d;
    logic [15:0]        shreg_q, shreg_d;

    logic               issue_vld, ack;
    logic [8:0]         issue_dat, wr_dat;
    logic               wr_en;

    logic [3:0]         w_m1;
    logic [4:0]         h_m1;
    logic [15:0]        x0, x1, y0, y1, colour;
    logic [9:0]         x_end, y_end;
    logic [6:0]         code_eff, glyph_idx;
    logic               oob;

    assign w_m1      = size_q ? 4'd15 : 4'd7;
    assign h_m1      = size_q ? 5'd31 : 5'd15;
    assign x0        = {7'd0, sx_q};
    assign y0        = {7'd0, sy_q};
    assign x1        = x0 + {12'd0, w_m1};
    assign y1        = y0 + {11'd0, h_m1};
    assign x_end     = {1'b0, sx_q} + {6'd0, w_m1} + 10'd1;
    assign y_end     = {1'b0, sy_q} + {5'd0, h_m1} + 10'd1;
    assign oob       = (x_end > 10'(LCD_W)) || (y_end > 10'(LCD_H));
    assign code_eff  = (code_q < ASCII_FIRST || code_q > ASCII_LAST) ? ASCII_FIRST : code_q;
    assign glyph_idx = code_eff - ASCII_FIRST;
    assign colour    = shreg_q[15] ? FG_COLOR : BG_COLOR;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        code_d    = code_q;
        size_d    = size_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        base_d    = base_q;
        row_d     = row_q;
        col_d     = col_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        issue_vld = 1'b0;
        issue_dat = '0;
        case (state_q)
            IDLE: if (show_char_flag) begin
                code_d  = ascii_num;
                size_d  = en_size;
                sx_d    = start_x;
                sy_d    = start_y;
                state_d = CHECK;
            end
            CHECK: begin
                base_d  = size_q ? FONT_AW'({glyph_idx, 5'd0}) : FONT_AW'({glyph_idx, 4'd0});
                row_d   = '0;
                col_d   = '0;
                idx_d   = '0;
                state_d = oob ? DONE : CMD;
            end
            CMD: begin
                issue_vld = 1'b1;
                issue_dat = cmd_word(idx_q, x0, x1, y0, y1);
                ret_d     = CMD;
                state_d   = WAIT;
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                // The 8x16 bank only populates the low byte; left-align it so bit 15 is always the current pixel.
                shreg_d = size_q ? font_q : {font_q[7:0], 8'h00};
                state_d = PIX_HI;
            end
            PIX_HI: begin
                issue_vld = 1'b1;
                issue_dat = {1'b1, colour[15:8]};
                ret_d     = PIX_HI;
                state_d   = WAIT;
            end
            PIX_LO: begin
                issue_vld = 1'b1;
                issue_dat = {1'b1, colour[7:0]};
                ret_d     = PIX_LO;
                state_d   = WAIT;
            end
            WAIT: if (ack) begin
                case (ret_q)
                    CMD: begin
                        if (idx_q == 4'd10) state_d = FETCH;
                        else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = CMD;
                        end
                    end
                    PIX_HI: state_d = PIX_LO;
                    PIX_LO: begin
                        shreg_d = {shreg_q[14:0], 1'b0};
                        if (col_q == w_m1) begin
                            col_d = '0;
                            if (row_q == h_m1) state_d = DONE;
                            else begin
                                row_d   = row_q + 5'd1;
                                state_d = FETCH;
                            end
                        end else begin
                            col_d   = col_q + 4'd1;
                            state_d = PIX_HI;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            code_q  <= '0;
            size_q  <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            base_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            code_q  <= code_d;
            size_q  <= size_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            base_q  <= base_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    lcd_word_issuer u_issuer (
        .clk         (sys_clk_50MHz),
        .rst         (sys_rst),
        .issue_vld_i (issue_vld),
        .issue_dat_i (issue_dat),
        .wr_done_i   (wr.wr_done),
        .wr_dat_o    (wr_dat),
        .wr_en_o     (wr_en),
        .ack_o       (ack)
    );

    assign wr.show_char_data     = wr_dat;
    assign wr.en_write_show_char = wr_en;
    assign font_addr             = base_q + FONT_AW'(row_q);
    assign font_size             = size_q;
    assign show_char_done        = (state_q == DONE);
    assign busy                  = (state_q != IDLE) && (state_q != DONE);
endmodule
